mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the CPU's single unified memory port between the instruction-fetch requester and the data-access requester (memory stage loads/stores, stack push/pop during CALL/RET/interrupt entry). Data has priority by default. A wait counter keeps fetch from starving. A lock input lets multi-byte stack sequences complete without interleaving. The block sits between the IF/MEM pipeline stages and the memory unit, and drives that memory's enable, write-enable, address and write-data.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MAX_WAIT, 4, consecutive denied fetch cycles after which fetch wins (1..15)

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- f_req  in  1  fetch request
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch read data valid (cycle after grant)
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_lock  in  1  hold data ownership for the next cycle (multi-byte sequence)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  data read valid (cycle after a granted read)
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- State: wait_cnt (4 bits, saturating at MAX_WAIT), locked (1 bit), rd_owner (2 bits: NONE/FETCH/DATA).
- Grant (combinational, same cycle as request):
  - locked=1 and d_req=1 -> data.
  - Else, wait_cnt==MAX_WAIT and f_req=1 -> fetch.
  - Else, d_req=1 -> data.
  - Else, f_req=1 -> fetch.
  - Else, none.
- At most one of f_gnt/d_gnt is high. mem_en = f_gnt|d_gnt. mem_we = d_gnt&d_we.
- mem_addr/mem_wdata mux the granted requester. When idle, they hold 0.
- wait_cnt:
  - Clears on f_gnt or f_req=0.
  - Increments when f_req=1 and f_gnt=0.
  - Saturates at MAX_WAIT.
- locked:
  - Next value = d_gnt & d_lock.
  - Cleared when d_req drops, even if d_lock stays high.
  - Lock overrides the starvation rule.
- rd_owner:
  - Next value = FETCH on f_gnt, DATA on d_gnt with d_we=0, else NONE.
  - f_rvalid = (rd_owner==FETCH); d_rvalid = (rd_owner==DATA).
  - f_rdata and d_rdata both carry mem_rdata; each is meaningful only while its rvalid is high.
- Writes produce no rvalid.

## Timing
- Reset (reset=0, asynchronous):
  - wait_cnt=0, locked=0, rd_owner=NONE.
  - f_gnt, d_gnt, mem_en and mem_we are forced 0 while reset is low, regardless of requests.
  - f_rvalid=d_rvalid=0. mem_addr=mem_wdata=0.
- Reset asserted mid-access: the pending rvalid is dropped and never issued.
- Grant latency: 0 cycles (same cycle as request). Read latency: 1 cycle after grant. Throughput: one access per cycle.
- Requesters hold req/addr/we/wdata stable until they see gnt. Gnt is valid only in the cycle it is asserted.
- Simultaneous f_req and d_req with wait_cnt<MAX_WAIT and no lock: data wins, wait_cnt increments.
- Worst-case fetch wait without lock: MAX_WAIT cycles. Lock sequences extend this only while d_req and d_lock stay high.

## Test plan
- Reset: hold reset=0 with f_req=d_req=1 -> f_gnt=d_gnt=mem_en=0. Release reset with f_req=1 only, f_addr=8'h10 -> f_gnt=1, mem_addr=10 same cycle. Next cycle f_rvalid=1 and f_rdata=mem[10].
- Priority: f_req=d_req=1, d_we=0, d_addr=8'h80 -> d_gnt=1, mem_addr=80, mem_we=0. Next cycle d_rvalid=1, f_rvalid=0.
- Starvation, MAX_WAIT=4: d_req held high with no lock, f_req held high -> d_gnt on cycles 1-4, f_gnt on cycle 5, wait_cnt back to 0, d_gnt again on cycle 6.
- Lock: as above, but d_lock=1 for 6 cycles -> d_gnt all 6 cycles with wait_cnt saturated at 4. When d_lock drops, f_gnt follows on the next cycle.
- Write: d_req=1, d_we=1, d_addr=8'hFE, d_wdata=8'hA5 -> mem_we=1, mem_wdata=A5 same cycle. No d_rvalid next cycle. A read of FE then returns A5.
- Async reset mid-read: grant a fetch read, then drop reset before the next edge -> f_rvalid stays 0 and all state is cleared.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// and data access. Data wins by default. A saturating wait counter lets a
// starved fetch through, and a lock keeps multi-byte data sequences together.
// Grants are combinational, in the same cycle as the request. Read data comes
// back one cycle after a granted read and is steered by a registered read owner.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    // fetch requester
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    // data requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Who owns the read data returning in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic       locked;
    logic       locked_nxt;
    owner_t     rd_owner;
    owner_t     rd_owner_nxt;

    // Grant selection: lock, then starvation escape, then data, then fetch.
    // Reset low blocks every grant, whatever the requests are.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // block leaves a signal unassigned and no latch is inferred.
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (locked && d_req) begin
                d_gnt = 1'b1;
            end else if ((wait_cnt == WAIT_LIMIT) && f_req) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    // Memory port mux: drive the granted requester, zeros when idle.
    always_comb begin
        mem_en    = f_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Next-state logic for the wait counter, lock flag and read owner.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        locked_nxt   = d_gnt & d_lock;
        rd_owner_nxt = OWN_NONE;

        if (!f_req || f_gnt) begin
            wait_cnt_nxt = 4'd0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
        end

        if (f_gnt) begin
            rd_owner_nxt = OWN_FETCH;
        end else if (d_gnt && !d_we) begin
            rd_owner_nxt = OWN_DATA;
        end
    end

    // State registers, cleared asynchronously so a pending rvalid is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
            locked   <= 1'b0;
            rd_owner <= OWN_NONE;
        end else begin
            // NOTE: non-blocking assignments here, so each register samples
            // the pre-edge values regardless of statement order.
            wait_cnt <= wait_cnt_nxt;
            locked   <= locked_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end

    // Read return: both ports see memory data, the rvalids say who owns it.
    assign f_rvalid = (rd_owner == OWN_FETCH);
    assign d_rvalid = (rd_owner == OWN_DATA);
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of mem_port_arbiter with a small
// synchronous memory model behind the port. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later, away from the edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [256];

    int checks;
    int errors;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_lock   (d_lock),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: writes land on the edge, reads return next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req  = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        d_lock = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Memory preload: mem[a] = a ^ 8'h5A.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem_rdata = '0;

        // ---- Reset held with both requesters active ----
        reset   = 1'b0;
        f_req   = 1'b1;
        f_addr  = 8'h44;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_lock  = 1'b1;
        d_addr  = 8'h33;
        d_wdata = 8'h77;
        #2;
        check("rst_f_gnt",    8'(f_gnt),    8'h00);
        check("rst_d_gnt",    8'(d_gnt),    8'h00);
        check("rst_mem_en",   8'(mem_en),   8'h00);
        check("rst_mem_we",   8'(mem_we),   8'h00);
        check("rst_mem_addr", mem_addr,     8'h00);
        check("rst_mem_wdat", mem_wdata,    8'h00);
        step();
        step();
        check("rst_f_rvalid", 8'(f_rvalid), 8'h00);
        check("rst_d_rvalid", 8'(d_rvalid), 8'h00);
        check("rst_en_held",  8'(mem_en),   8'h00);

        // ---- Release reset, fetch only from 0x10 ----
        reset  = 1'b1;
        idle();
        f_req  = 1'b1;
        f_addr = 8'h10;
        #1;
        check("rel_f_gnt",    8'(f_gnt),    8'h01);
        check("rel_d_gnt",    8'(d_gnt),    8'h00);
        check("rel_mem_addr", mem_addr,     8'h10);
        check("rel_mem_we",   8'(mem_we),   8'h00);
        step();
        check("rel_f_rvalid", 8'(f_rvalid), 8'h01);
        check("rel_f_rdata",  f_rdata,      8'h4A);
        check("rel_d_rvalid", 8'(d_rvalid), 8'h00);

        // ---- Priority: data read wins over fetch ----
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 8'h80;
        #1;
        check("pri_d_gnt",    8'(d_gnt),    8'h01);
        check("pri_f_gnt",    8'(f_gnt),    8'h00);
        check("pri_mem_addr", mem_addr,     8'h80);
        check("pri_mem_we",   8'(mem_we),   8'h00);
        step();
        check("pri_d_rvalid", 8'(d_rvalid), 8'h01);
        check("pri_d_rdata",  d_rdata,      8'hDA);
        check("pri_f_rvalid", 8'(f_rvalid), 8'h00);

        // ---- Idle: port quiet, wait counter cleared ----
        idle();
        #1;
        check("idle_mem_en",   8'(mem_en), 8'h00);
        check("idle_mem_addr", mem_addr,   8'h00);
        step();
        check("idle_d_rvalid", 8'(d_rvalid), 8'h00);

        // ---- Starvation: data wins 4 cycles, fetch on cycle 5, data on 6 ----
        f_req  = 1'b1;
        f_addr = 8'h11;
        d_req  = 1'b1;
        d_addr = 8'h81;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("stv%0d_f_gnt", c), 8'(f_gnt), 8'(c == 5));
            check($sformatf("stv%0d_d_gnt", c), 8'(d_gnt), 8'(c != 5));
            check($sformatf("stv%0d_addr", c), mem_addr, (c == 5) ? 8'h11 : 8'h81);
            step();
            check($sformatf("stv%0d_f_rv", c), 8'(f_rvalid), 8'(c == 5));
            check($sformatf("stv%0d_d_rv", c), 8'(d_rvalid), 8'(c != 5));
        end
        check("stv_f_rdata", f_rdata, 8'hDB);
        idle();
        step();

        // ---- Lock: d_lock high cycles 1-6 holds data through cycle 7,
        //      fetch follows on cycle 8, data again on cycle 9 ----
        f_req = 1'b1;
        d_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            d_lock = (c <= 6);
            #1;
            check($sformatf("lck%0d_f_gnt", c), 8'(f_gnt), 8'(c == 8));
            check($sformatf("lck%0d_d_gnt", c), 8'(d_gnt), 8'(c != 8));
            step();
        end
        idle();
        step();

        // ---- Write 0xA5 to 0xFE: no rvalid, then read it back ----
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 8'hFE;
        d_wdata = 8'hA5;
        #1;
        check("wr_d_gnt",     8'(d_gnt),  8'h01);
        check("wr_mem_we",    8'(mem_we), 8'h01);
        check("wr_mem_addr",  mem_addr,   8'hFE);
        check("wr_mem_wdata", mem_wdata,  8'hA5);
        step();
        check("wr_d_rvalid",  8'(d_rvalid), 8'h00);
        d_we = 1'b0;
        #1;
        check("rb_mem_we",    8'(mem_we), 8'h00);
        step();
        check("rb_d_rvalid",  8'(d_rvalid), 8'h01);
        check("rb_d_rdata",   d_rdata,      8'hA5);
        idle();
        step();

        // ---- Reset dropped after grant, before the capturing edge ----
        f_req  = 1'b1;
        f_addr = 8'h20;
        #1;
        check("ar1_f_gnt",    8'(f_gnt), 8'h01);
        reset = 1'b0;
        #1;
        check("ar1_gnt_kill", 8'(f_gnt),  8'h00);
        check("ar1_en_kill",  8'(mem_en), 8'h00);
        step();
        check("ar1_f_rvalid", 8'(f_rvalid), 8'h00);
        idle();
        reset = 1'b1;
        step();
        check("ar1_f_rv_post", 8'(f_rvalid), 8'h00);

        // ---- Reset dropped while the read data is pending ----
        f_req  = 1'b1;
        f_addr = 8'h21;
        step();
        check("ar2_f_rvalid", 8'(f_rvalid), 8'h01);
        reset = 1'b0;
        #1;
        check("ar2_rv_async", 8'(f_rvalid), 8'h00);
        idle();
        step();
        reset = 1'b1;
        // All state cleared: data wins over fetch and no lock lingers.
        f_req  = 1'b1;
        d_req  = 1'b1;
        d_addr = 8'h82;
        #1;
        check("ar2_d_gnt",    8'(d_gnt), 8'h01);
        check("ar2_f_gnt",    8'(f_gnt), 8'h00);
        step();
        check("ar2_d_rvalid", 8'(d_rvalid), 8'h01);
        check("ar2_d_rdata",  d_rdata,      8'hD8);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
